// File: rtl/gate_tb_pkg.sv
// Purpose: shared types and truth-table constants for the gate truth checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bit k is the expected gate output for input vector k (vec[0]=a, vec[1]=b).
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

    // Error counter width: must hold every count from 0 up to 2**n mismatches.
    function automatic int err_w(input int n);
        return $clog2((2 ** n) + 1);
    endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Purpose: bundles the checker's control, stimulus and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level sampled only while the checker is idle.
interface gate_truth_checker_if #(
    parameter int N_IN = 2
);
    import gate_tb_pkg::*;

    localparam int EW = err_w(N_IN);

    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [EW-1:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] fail_vec;

    // Checker side: drives stimulus and results, consumes start and the gate output.
    modport master (
        input  start,
        input  dut_out,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output fail_vec
    );

    // Environment side: the gate under test plus whoever launches sweeps.
    modport slave (
        output start,
        output dut_out,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  fail_vec
    );

endinterface

// File: rtl/hold_timer.sv
// Purpose: counts the cycles a stimulus vector is held before its sample point.
// Latency: expire is asserted in the HOLD_CYCLES-th enabled cycle after clear.
// Backpressure: none; counting simply pauses while en is low.
module hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire = en && (cnt_q == TERM);

    // Next count: clear wins, otherwise count up and wrap to zero on expire.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Purpose: sweeps all input vectors of a small gate and checks its output against a truth table.
// Latency: done pulses 2**N_IN*HOLD_CYCLES+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy or finishing, never queued.
module gate_truth_checker
    import gate_tb_pkg::*;
#(
    parameter int                 N_IN        = 2,
    parameter int                 HOLD_CYCLES = 5,
    parameter logic [2**N_IN-1:0] EXPECTED    = TT_AND2
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_truth_checker_if.master bus
);

    localparam int              EW       = err_w(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [EW-1:0]   ERR_MAX  = {EW{1'b1}};

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] fail_vec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            fail_valid_q;
    logic [EW-1:0]   err_q;
    logic [EW-1:0]   err_d;
    logic            timer_clear;
    logic            timer_en;
    logic            sample;
    logic            mismatch;

    assign timer_clear = (state_q == IDLE) && bus.start;
    assign timer_en    = (state_q == DRIVE);

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .en    (timer_en),
        .expire(sample)
    );

    // Compare at the sample edge; X on the gate output counts as a mismatch.
    always_comb begin
        mismatch = 1'b0;
        err_d    = err_q;
        if (sample) begin
            mismatch = (bus.dut_out !== EXPECTED[vec_q]);
            if (mismatch && (err_q != ERR_MAX)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    // Sweep sequencer with registered outputs; done defaults low so it pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= DRIVE;
                        vec_q        <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= '0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        err_q <= err_d;
                        // Only the first failing vector is kept.
                        if (mismatch && !fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_vec_q   <= vec_q;
                        end
                        if (vec_q == LAST_VEC) begin
                            // Last vector stays on the bus; pass includes its own result.
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (err_d == '0);
                        end else begin
                            vec_q <= vec_q + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out    = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;

endmodule
